uart_bcd_reporter: RTL and testbench
====================================

// Module: uart_bcd_reporter
// PURPOSE
//  Transmit-side companion to the UART receive path: serialises a latched 16-bit BCD value onto a UART line.
//  Frame is four ASCII digits then CR LF. Bytes are 8N1, LSB first.
//  Sits beside the BCD counter / 7-segment path and reports the displayed count to the host over usb_tx.
//  Contains its own baud divider, bit serialiser and byte sequencer.
// PARAMETERS
//  ClkFreq      100000000  input clock frequency in Hz
//  BaudRate     115200     line rate; BaudDiv = ClkFreq/BaudRate, integer truncated (868 at defaults)
//  AutoOnChange 0          1: a change of Val while idle also starts a frame
// PORTS
//  Clk    input   1   system clock, rising edge
//  Reset  input   1   asynchronous, active-low reset
//  Val    input  16   BCD value: [15:12] thousands .. [3:0] units
//  Send   input   1   request; sampled high on a rising edge while idle starts a frame
//  Busy   output  1   high from the first start bit until the end of the last stop bit
//  Done   output  1   one-cycle pulse when a frame completes
//  Tx     output  1   UART serial out; idle level 1
// BEHAVIOUR
//  Reset (Reset=0, asynchronous): Tx=1, Busy=0, Done=0, FSM=IDLE, counters=0, latched value=0.
//   If asserted mid-frame, Tx returns to 1 immediately. After release the block waits in IDLE for a new Send.
//  Trigger, edge N: Send=1 in IDLE, or AutoOnChange=1 with Val != value of last sent frame.
//   Val is captured. From edge N+1: Busy=1, Tx=0 (start bit). One cycle of latency.
//  Byte order: ASCII(Val[15:12]), ASCII(Val[11:8]), ASCII(Val[7:4]), ASCII(Val[3:0]), 8'h0D, 8'h0A.
//  ASCII map: nibble 0-9 -> 8'h30+nibble; nibble 10-15 (invalid BCD) -> 8'h3F '?'.
//  Bit timing: every bit (start, d0..d7, stop) holds exactly BaudDiv clocks.
//   Bytes are back-to-back with no extra idle between stop and the next start.
//   Frame length = 60*BaudDiv clocks.
//  FSM states:
//   IDLE  -> START on trigger.
//   START -> DATA after BaudDiv clocks.
//   DATA  -> STOP after 8 bits; bit index 0..7.
//   STOP  -> START while byte index < 5; byte index increments.
//   STOP  -> IDLE at byte index 5. In the same edge: Busy=0, Done=1 for one cycle.
//  Baud counter counts 0..BaudDiv-1, then wraps to 0. It is cleared on every trigger so the first bit is full length.
//  Send or Val changes while Busy=1 are ignored. A request is not queued.
//   Send held high continuously re-triggers on the first cycle back in IDLE.
//   That cycle is the same edge in which Done drops.
//  Send and a Val change in the same cycle cause a single frame.
//  AutoOnChange compares against the value captured for the last frame. That value is 0 after reset.
// TESTING
//  1. Reset, Val=16'h1234, Send pulse 1 clk -> Busy next edge.
//     Tx decodes 31 32 33 34 0D 0A. Done pulse at 60*868 clks.
//  2. Val=16'h09AF -> bytes 30 39 3F 3F 0D 0A (invalid nibbles as '?').
//  3. Send pulse at clk 1000 of a frame -> ignored.
//     Only one frame is sent; Busy falls at 60*BaudDiv.
//  4. Reset driven low mid-DATA -> Tx=1 and Busy=0 in the same cycle, no Done.
//     A new Send then yields a complete correct frame.
//  5. AutoOnChange=1, Val 0000->0005 idle -> frame 30 30 30 35 0D 0A.
//     Val held -> no further frame.
//  6. ClkFreq=16, BaudRate=4 (BaudDiv=4) -> each bit exactly 4 clks; start-bit edge 1 clk after Send.

Source files
------------

// File: rtl/uart_bcd_reporter.sv
// UART transmitter that reports a latched 4-digit BCD value as ASCII digits plus CR LF (8N1, LSB first).
// Outputs are registered one cycle behind the FSM, so the start bit appears one clock after the trigger edge.
module uart_bcd_reporter #(
  parameter int ClkFreq      = 100000000,
  parameter int BaudRate     = 115200,
  parameter bit AutoOnChange = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Val,
  input  logic        Send,
  output logic        Busy,
  output logic        Done,
  output logic        Tx
);

  localparam int BaudDiv = ClkFreq / BaudRate;
  localparam int CntW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BaudDiv - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CntW-1:0] baud_cnt_r;
  logic [2:0]      bit_idx_r;
  logic [2:0]      byte_idx_r;
  logic [15:0]     val_r;
  logic            trigger_s;
  logic            tick_s;
  logic [7:0]      byte_s;
  logic            tx_s;
  logic            busy_s;
  logic            done_s;

  function automatic logic [7:0] bcd_ascii(input logic [3:0] nib);
    if (nib <= 4'd9) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h3F;
    end
  endfunction

  function automatic logic [7:0] frame_byte(input logic [15:0] v, input logic [2:0] idx);
    case (idx)
      3'd0:    return bcd_ascii(v[15:12]);
      3'd1:    return bcd_ascii(v[11:8]);
      3'd2:    return bcd_ascii(v[7:4]);
      3'd3:    return bcd_ascii(v[3:0]);
      3'd4:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Auto mode compares against the value of the last frame, not the previous cycle's Val.
  assign trigger_s = (state_r == IDLE) && (Send || (AutoOnChange && (Val != val_r)));
  assign tick_s    = (baud_cnt_r == CntMax);
  assign byte_s    = frame_byte(val_r, byte_idx_r);

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (trigger_s) state_s = START; else state_s = IDLE;
      START:   if (tick_s) state_s = DATA; else state_s = START;
      DATA:    if (tick_s && (bit_idx_r == 3'd7)) state_s = STOP; else state_s = DATA;
      STOP: begin
        if (tick_s) begin
          if (byte_idx_r == 3'd5) state_s = IDLE; else state_s = START;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Baud counter, bit/byte indices and value capture
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      val_r      <= 16'h0000;
    end else if (trigger_s) begin
      baud_cnt_r <= '0;
      bit_idx_r  <= 3'd0;
      byte_idx_r <= 3'd0;
      val_r      <= Val;
    end else if (state_r != IDLE) begin
      baud_cnt_r <= tick_s ? '0 : (baud_cnt_r + CntW'(1));
      if (tick_s) begin
        case (state_r)
          DATA:    bit_idx_r  <= bit_idx_r + 3'd1;
          STOP:    byte_idx_r <= (byte_idx_r == 3'd5) ? 3'd0 : (byte_idx_r + 3'd1);
          default: bit_idx_r  <= bit_idx_r;
        endcase
      end
    end
  end

  // FSM output decode; Done fires in the cycle the registered Busy still lags an idle FSM
  always_comb begin
    tx_s   = 1'b1;
    busy_s = (state_r != IDLE);
    done_s = (state_r == IDLE) && Busy;
    case (state_r)
      START:   tx_s = 1'b0;
      DATA:    tx_s = byte_s[bit_idx_r];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // Registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Tx   <= 1'b1;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Tx   <= tx_s;
      Busy <= busy_s;
      Done <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_bcd_reporter.sv
// Directed bench: dut_a uses BaudDiv=4 with manual Send, dut_b uses BaudDiv=7 (truncated) with AutoOnChange.
module tb_uart_bcd_reporter;

  logic        clk;
  logic        rst_a, rst_b;
  logic [15:0] val_a, val_b;
  logic        send_a, send_b;
  logic        busy_a, busy_b, done_a, done_b, tx_a, tx_b;
  int          cmp_cnt = 0;
  int          err_cnt = 0;

  uart_bcd_reporter #(.ClkFreq(16), .BaudRate(4), .AutoOnChange(1'b0)) dut_a (
    .Clk(clk), .Reset(rst_a), .Val(val_a), .Send(send_a),
    .Busy(busy_a), .Done(done_a), .Tx(tx_a)
  );

  uart_bcd_reporter #(.ClkFreq(50), .BaudRate(7), .AutoOnChange(1'b1)) dut_b (
    .Clk(clk), .Reset(rst_b), .Val(val_b), .Send(send_b),
    .Busy(busy_b), .Done(done_b), .Tx(tx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at the negedge right after the trigger edge; walks the whole frame clock by clock.
  task automatic frame_check(input bit sel, input int d, input logic [47:0] expb,
                             input int inject_at, input string tag);
    logic [9:0] obs;
    logic [9:0] want;
    logic       t;
    bit         glitch;
    bit         busy_low;
    int         cyc;
    check($sformatf("%s_lat_tx", tag), 16'(sel ? tx_b : tx_a), 16'h0001);
    check($sformatf("%s_lat_busy", tag), 16'(sel ? busy_b : busy_a), 16'h0000);
    glitch = 1'b0;
    busy_low = 1'b0;
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      want = {1'b1, expb[47-8*k -: 8], 1'b0};
      obs = 10'h000;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < d; c++) begin
          @(negedge clk);
          cyc++;
          if (inject_at > 0) send_a = (cyc == inject_at);
          t = sel ? tx_b : tx_a;
          if (c == 0) obs[j] = t;
          else if (t !== obs[j]) glitch = 1'b1;
          if ((sel ? busy_b : busy_a) !== 1'b1) busy_low = 1'b1;
        end
      end
      check($sformatf("%s_byte%0d", tag, k), {6'h00, obs}, {6'h00, want});
    end
    check($sformatf("%s_bit_len", tag), 16'(glitch), 16'h0000);
    check($sformatf("%s_busy_held", tag), 16'(busy_low), 16'h0000);
    @(negedge clk);
    check($sformatf("%s_end_busy", tag), 16'(sel ? busy_b : busy_a), 16'h0000);
    check($sformatf("%s_end_done", tag), 16'(sel ? done_b : done_a), 16'h0001);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), 16'(sel ? done_b : done_a), 16'h0000);
  endtask

  task automatic idle_check(input bit sel, input int n, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ((sel ? busy_b : busy_a) !== 1'b0 || (sel ? done_b : done_a) !== 1'b0) seen = 1'b1;
    end
    check(tag, 16'(seen), 16'h0000);
  endtask

  task automatic pulse_send_a(input logic [15:0] v);
    @(negedge clk);
    val_a = v;
    send_a = 1'b1;
    @(negedge clk);
    send_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    val_a = 16'h0000; val_b = 16'h0000;
    send_a = 1'b0; send_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx_a", 16'(tx_a), 16'h0001);
    check("rst_busy_a", 16'(busy_a), 16'h0000);
    check("rst_done_a", 16'(done_a), 16'h0000);
    check("rst_tx_b", 16'(tx_b), 16'h0001);
    check("rst_busy_b", 16'(busy_b), 16'h0000);
    rst_a = 1'b1; rst_b = 1'b1;
    idle_check(1'b0, 4, "idle_after_rst_a");

    // Basic frame and invalid-BCD mapping
    pulse_send_a(16'h1234);
    frame_check(1'b0, 4, 48'h31_32_33_34_0D_0A, 0, "f1234");
    pulse_send_a(16'h09AF);
    frame_check(1'b0, 4, 48'h30_39_3F_3F_0D_0A, 0, "f09af");

    // A Send pulse mid-frame must not queue a second frame
    pulse_send_a(16'h7777);
    frame_check(1'b0, 4, 48'h37_37_37_37_0D_0A, 30, "fignore");
    send_a = 1'b0;
    idle_check(1'b0, 12, "no_requeue");

    // Asynchronous reset during the first data bit of '2' (d0=0)
    pulse_send_a(16'h2000);
    repeat (8) @(negedge clk);
    check("pre_rst_tx", 16'(tx_a), 16'h0000);
    rst_a = 1'b0;
    #1;
    check("mid_rst_tx", 16'(tx_a), 16'h0001);
    check("mid_rst_busy", 16'(busy_a), 16'h0000);
    check("mid_rst_done", 16'(done_a), 16'h0000);
    @(negedge clk);
    rst_a = 1'b1;
    idle_check(1'b0, 6, "post_rst_idle");
    pulse_send_a(16'h5678);
    frame_check(1'b0, 4, 48'h35_36_37_38_0D_0A, 0, "f5678");

    // Auto-on-change instance: no frame while Val equals the reset capture
    idle_check(1'b1, 10, "auto_idle_zero");
    @(negedge clk);
    val_b = 16'h0005;
    @(negedge clk);
    frame_check(1'b1, 7, 48'h30_30_30_35_0D_0A, 0, "auto0005");
    idle_check(1'b1, 20, "auto_held");

    // Send and a Val change together give exactly one frame
    @(negedge clk);
    val_b = 16'h0042;
    send_b = 1'b1;
    @(negedge clk);
    send_b = 1'b0;
    frame_check(1'b1, 7, 48'h30_30_34_32_0D_0A, 0, "auto_both");
    idle_check(1'b1, 20, "auto_single");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
